// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte handshake between the processor side and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  logic tx_err;
  logic busy;
  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_err, busy);
  modport slave (input tx_data, tx_valid, output tx_ready, tx_done, tx_err, busy);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter; define PS2_TX_RETRY_EN for one automatic retry after an error
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN = 8
) (
  input logic clock,
  input logic reset,
  ps2_host_tx_if.slave host,
  input logic ps2_clk_in,
  input logic ps2_dat_in,
  output logic ps2_clk_drive_low,
  output logic ps2_dat_drive_low
);
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] INHIBIT = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] BITS = 3'd3;
  localparam logic [2:0] ACK = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
  localparam logic [2:0] DONE = 3'd6;
  localparam logic [2:0] ERR = 3'd7;
  logic [2:0] state;
  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] hist;
  logic filt, filt_nxt, fall;
  logic [9:0] frame;
  logic [3:0] idx;
  logic [31:0] cnt;
  logic dat_low, retried, watch, bad;
  // the filtered clock only moves once the whole sample window agrees
  assign filt_nxt = &hist ? 1'b1 : (|hist ? filt : 1'b0);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'hf;
      hist <= '1;
      filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
      hist <= {hist[FILTER_LEN-2:0], clk_s2};
      filt <= filt_nxt;
      fall <= filt & ~filt_nxt;
    end
  assign watch = state == BITS || state == ACK || state == WAIT_IDLE;
  assign bad = watch && (cnt == 32'(TIMEOUT_CYCLES - 1) || (state == ACK && fall && dat_s2));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      frame <= '0;
      dat_low <= 1'b0;
      retried <= 1'b0;
    end else if (bad) begin
      dat_low <= 1'b0;
      cnt <= '0;
      retried <= 1'b1;
      state <= RETRY && !retried ? INHIBIT : ERR;
    end else
      case (state)
        IDLE:
          if (host.tx_valid) begin
            frame <= {1'b1, ~^host.tx_data, host.tx_data};
            retried <= 1'b0;
            cnt <= '0;
            state <= INHIBIT;
          end
        INHIBIT:
          if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
            cnt <= '0;
            dat_low <= 1'b1;
            state <= START;
          end else cnt <= cnt + 32'd1;
        START: begin
          idx <= '0;
          state <= BITS;
        end
        BITS: begin
          cnt <= cnt + 32'd1;
          if (fall) begin
            dat_low <= ~frame[idx];
            idx <= idx + 4'd1;
            state <= idx == 4'd9 ? ACK : BITS;
          end
        end
        ACK: begin
          cnt <= cnt + 32'd1;
          if (fall) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          cnt <= cnt + 32'd1;
          if (filt && dat_s2) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  assign ps2_clk_drive_low = state == INHIBIT || state == START;
  assign ps2_dat_drive_low = dat_low;
  assign host.tx_ready = state == IDLE;
  assign host.busy = state != IDLE;
  assign host.tx_done = state == DONE;
  assign host.tx_err = state == ERR;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model driving ps2_host_tx, checked against frame rules computed from the byte
module tb_ps2_host_tx;
  localparam int INH = 60;
  localparam int TO = 2000;
  localparam int H = 30;
`ifdef PS2_TX_RETRY_EN
  localparam int ATT = 2;
`else
  localparam int ATT = 1;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic clk_drive_low, dat_drive_low, ps2_clk_in, ps2_dat_in;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
    .clock(clock),
    .reset(reset),
    .host(bus),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_drive_low(clk_drive_low),
    .ps2_dat_drive_low(dat_drive_low)
  );
  always #10 clock = ~clock;
  assign ps2_clk_in = ~(clk_drive_low | dev_clk_low);
  assign ps2_dat_in = ~(dat_drive_low | dev_dat_low);
  always @(posedge clock)
    if (!reset) begin
      done_cnt += int'(bus.tx_done);
      err_cnt += int'(bus.tx_err);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask
  // one half period of the device clock, optionally with a 3-cycle glitch of the opposite level
  task automatic phase(input logic low, input bit gl);
    for (int c = 0; c < H; c++) begin
      dev_clk_low = (gl && c >= 18 && c < 21) ? ~low : low;
      tick();
    end
  endtask
  task automatic device(input int nbits, input bit ack, input bit gl, input bit first, output logic [9:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!clk_drive_low && n < 200) begin tick(); n++; end
    check("inhibit_seen", 32'(clk_drive_low), 1);
    n = 0;
    while (clk_drive_low && n < INH + 200) begin tick(); n++; end
    if (first) check("inhibit_len", n, INH + 1);
    check("start_bit", 32'(dat_drive_low), 1);
    tick(30);
    for (int i = 0; i < nbits; i++) begin
      phase(1'b1, gl);
      bits[i] = ps2_dat_in;
      phase(1'b0, gl);
    end
    if (nbits == 10) begin
      dev_dat_low = ack;
      phase(1'b1, 1'b0);
      if (ack) phase(1'b0, 1'b0);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    tick();
    check("accept_busy", 32'(bus.busy), 1);
    check("accept_ready", 32'(bus.tx_ready), 0);
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'($urandom);
  endtask
  task automatic run_xfer(input logic [7:0] b, input bit ack, input bit gl);
    logic [9:0] bits;
    int d0, e0, n;
    bit par;
    par = ($countones(b) % 2) == 0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    for (int a = 0; a < (ack ? 1 : ATT); a++) begin
      device(10, ack, gl, a == 0, bits);
      if (a == 0) begin
        check("data_bits", 32'(bits[7:0]), 32'(b));
        check("parity_bit", 32'(bits[8]), 32'(par));
        check("stop_bit", 32'(bits[9]), 1);
      end
    end
    n = 0;
    while (bus.busy && n < 200) begin
      if (bus.tx_done) check("ready_at_done", 32'(bus.tx_ready), 0);
      tick();
      n++;
    end
    check("ready_after", 32'(bus.tx_ready), 1);
    check("lines_released", 32'({clk_drive_low, dat_drive_low}), 0);
    tick();
    check("done_pulses", done_cnt - d0, 32'(ack));
    check("err_pulses", err_cnt - e0, 32'(!ack));
  endtask
  task automatic run_timeout(input logic [7:0] b);
    int n, e0;
    e0 = err_cnt;
    send(b);
    for (int a = 0; a < ATT; a++) begin
      n = 0;
      while (!clk_drive_low && n < 200) begin tick(); n++; end
      n = 0;
      while (clk_drive_low && n < INH + 200) begin tick(); n++; end
      n = 0;
      while (!bus.tx_err && !clk_drive_low && n < TO + 50) begin tick(); n++; end
      check("timeout_cycles", n, TO);
    end
    check("timeout_err", 32'(bus.tx_err), 1);
    check("timeout_released", 32'({clk_drive_low, dat_drive_low}), 0);
    tick();
    check("timeout_ready", 32'(bus.tx_ready), 1);
    check("timeout_err_pulses", err_cnt - e0, 1);
  endtask
  initial begin
    logic [9:0] bits;
    logic [7:0] b;
    int d0, e0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    tick(3);
    check("rst_ready", 32'(bus.tx_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pulses", 32'({bus.tx_done, bus.tx_err}), 0);
    check("rst_drives", 32'({clk_drive_low, dat_drive_low}), 0);
    reset = 1'b0;
    tick(3);
    check("idle_ready", 32'(bus.tx_ready), 1);
    run_xfer(8'hED, 1'b1, 1'b0);
    run_xfer(8'hFF, 1'b1, 1'b0);
    run_xfer(8'hED, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      run_xfer(b, 1'b1, 1'($urandom_range(0, 1)));
    end
    run_xfer(8'hED, 1'b0, 1'b0);
    tick(5);
    run_timeout(8'h5A);
    tick(5);
    b = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    device(4, 1'b1, 1'b0, 1'b1, bits);
    check("partial_bits", 32'(bits[3:0]), 32'(b[3:0]));
    tick(5);
    #3 reset = 1'b1;
    #1;
    check("async_rst_drives", 32'({clk_drive_low, dat_drive_low}), 0);
    check("async_rst_ready", 32'(bus.tx_ready), 1);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    run_xfer(8'h00, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 port; the opposite direction to the existing keyboard receive path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using the standard PS/2 host-request sequence.
- Drives the open-drain ps2_clock/ps2_data lines via active-low-drive enables. The top level turns these into tri-state drivers.
- Reports completion or error to the processor/MMIO side with a valid/ready byte handshake.

Parameters:
- INHIBIT_CYCLES, 5000: clock cycles the host holds ps2 clock low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max cycles from clock release to end of ACK before an error (15 ms at 50 MHz).
- FILTER_LEN, 8: consecutive equal synchronized samples needed to accept a new ps2 clock level.

Ports:
- clock, in, 1: system clock (50 MHz).
- reset, in, 1: asynchronous, active-high reset.
- tx_data, in, 8: command byte.
- tx_valid, in, 1: request to send tx_data.
- tx_ready, out, 1: block idle; a transfer is accepted when tx_valid && tx_ready.
- tx_done, out, 1: one-cycle pulse, byte sent and ACK received.
- tx_err, out, 1: one-cycle pulse, timeout or missing ACK.
- busy, out, 1: high from acceptance until tx_done/tx_err.
- ps2_clk_in, in, 1: raw ps2 clock pin level.
- ps2_dat_in, in, 1: raw ps2 data pin level.
- ps2_clk_drive_low, out, 1: 1 pulls ps2 clock low; 0 releases it.
- ps2_dat_drive_low, out, 1: 1 pulls ps2 data low; 0 releases it.

Behaviour:
- Reset values: tx_ready=1, tx_done=0, tx_err=0, busy=0, both drive_low=0, state=IDLE, counters=0. Reset mid-transfer aborts immediately and releases both lines; no pulse is emitted.
- Input conditioning:
  - 2-flop synchronizer on both pins.
  - ps2 clock passes through a FILTER_LEN-sample glitch filter.
  - fall = filtered clock 1->0, registered. It is seen 2 + FILTER_LEN + 1 cycles after the pin edge.
  - Data is sampled from its synchronized value at fall.
- Shift register: a 10-bit frame {stop=1, parity, data[7:0]}. Parity is odd, i.e. parity = ~^tx_data. The frame is latched at acceptance. tx_data changes during busy are ignored.
- States:
  - IDLE: tx_ready=1. On tx_valid -> INHIBIT, busy=1, tx_ready=0 next cycle.
  - INHIBIT: clk_drive_low=1 for INHIBIT_CYCLES cycles, then -> START.
  - START: dat_drive_low=1 (start bit 0) with clock still held one cycle, then release clock -> BITS. Timeout counter starts.
  - BITS: on each fall, put the next frame bit on data, LSB first (drive_low = ~bit). Falls 1-8 send data, fall 9 sends parity, fall 10 sends stop (release data) -> ACK.
  - ACK: at the next fall, sample data. Data 0 -> WAIT_IDLE; data 1 -> ERR.
  - WAIT_IDLE: wait until filtered clock=1 and synchronized data=1, then -> DONE.
  - DONE: tx_done=1 for one cycle -> IDLE.
  - ERR: release both lines, tx_err=1 for one cycle -> IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in BITS, ACK or WAIT_IDLE -> ERR.
- A device pulling clock low during INHIBIT has no effect; the host owns the bus.
- tx_valid held high after DONE starts a new transfer on the first IDLE cycle.
- Only one of tx_done/tx_err pulses per accepted byte.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on the first ACK-missing or timeout error, restart from INHIBIT with the same latched frame and no tx_err. tx_err pulses only if the retry also fails; busy stays high throughout.
- Undefined: the first error goes straight to ERR.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs -> clock held low ≥5000 cycles; data bits sampled on rising edges = 1,0,1,1,0,1,1,1; parity=1; stop=1; one tx_done pulse; tx_err never asserted.
- Send 0xFF, model ACKs -> parity bit=1 (eight ones, odd parity); tx_done pulse; tx_ready returns 1 the following cycle.
- Model releases data at the ACK fall (no ACK) -> tx_err pulse after fall 11, lines released. With PS2_TX_RETRY_EN, a second INHIBIT occurs first, and tx_err follows only if the retry also has no ACK.
- Model never clocks after the start bit -> tx_err exactly TIMEOUT_CYCLES after clock release; both drive_low=0 afterwards.
- Assert reset during BITS, after fall 4 -> both drive_low=0 and tx_ready=1 immediately (asynchronous); no done/err pulse; next 0x00 transfer completes normally with parity=1.
- Inject 3-cycle clock glitches during BITS -> no extra bits shifted; the 0xED frame is still correct.
